// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the stack sequencer, the stack pointer register and the decoder.
package stack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MEM_WR = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_SP_UPD = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam logic [7:0] STACK_TOP_DEF   = 8'hFF;
  localparam logic [7:0] STACK_FLOOR_DEF = 8'h80;

endpackage

// File: rtl/stack_sequencer_if.sv
// Request/response, memory and stack-pointer port bundle of the stack sequencer.
interface stack_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  // req: transfer when req_valid && req_ready at a rising edge; rsp_valid is a
  // one-cycle pulse with no backpressure; mem_we/mem_re hold until mem_ready.
  logic          req_valid;
  logic          req_ready;
  logic          req_pop;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] sp_cur;
  logic [AW-1:0] sp_next;
  logic          sp_we;
  logic          sp_is_pop;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          full;
  logic          empty;

  modport slave (
    input  req_valid, req_pop, req_wdata, sp_cur, mem_rdata, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, sp_next, sp_we, sp_is_pop,
           mem_addr, mem_wdata, mem_we, mem_re, full, empty
  );

  modport master (
    output req_valid, req_pop, req_wdata, sp_cur, mem_rdata, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, sp_next, sp_we, sp_is_pop,
           mem_addr, mem_wdata, mem_we, mem_re, full, empty
  );
endinterface

// File: rtl/stack_sequencer.sv
// Executes one PUSH/POP at a time: bounds check, memory handshake, pointer write-back, response.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int            DW          = 8,
  parameter int            AW          = 8,
  parameter logic [AW-1:0] STACK_TOP   = AW'(STACK_TOP_DEF),
  parameter logic [AW-1:0] STACK_FLOOR = AW'(STACK_FLOOR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  stack_sequencer_if.slave   bus,
  output state_t             dbg_state
);

  localparam logic [AW-1:0] SP_FULL = STACK_FLOOR - AW'(1);
  localparam logic [AW-1:0] ONE     = AW'(1);

  state_t        state_q, state_d;
  logic          pop_q, pop_d;
  logic          err_q, err_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] sp_q, sp_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_re_q, mem_re_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          sp_we_q, sp_we_d;
  logic [AW-1:0] sp_next_q, sp_next_d;
  logic          sp_is_pop_q, sp_is_pop_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          reject;

  assign bus.full      = (bus.sp_cur == SP_FULL);
  assign bus.empty     = (bus.sp_cur == STACK_TOP);
  assign bus.req_ready = (state_q == ST_IDLE) && !rst;
  assign reject        = bus.req_pop ? bus.empty : bus.full;

  always_comb begin
    state_d     = state_q;
    pop_d       = pop_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    sp_d        = sp_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    sp_we_d     = 1'b0;
    sp_next_d   = '0;
    sp_is_pop_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          pop_d   = bus.req_pop;
          wdata_d = bus.req_wdata;
          sp_d    = bus.sp_cur;
          err_d   = reject;
          if (reject) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (bus.req_pop) begin
            state_d    = ST_MEM_RD;
            mem_re_d   = 1'b1;
            mem_addr_d = bus.sp_cur + ONE;
          end else begin
            state_d     = ST_MEM_WR;
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.sp_cur;
            mem_wdata_d = bus.req_wdata;
          end
        end
      end
      ST_MEM_WR: begin
        if (bus.mem_ready) begin
          state_d   = ST_SP_UPD;
          sp_we_d   = 1'b1;
          sp_next_d = sp_q - ONE;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = sp_q;
          mem_wdata_d = wdata_q;
        end
      end
      ST_MEM_RD: begin
        if (bus.mem_ready) begin
          state_d     = ST_SP_UPD;
          rdata_d     = bus.mem_rdata;
          sp_we_d     = 1'b1;
          sp_next_d   = sp_q + ONE;
          sp_is_pop_d = 1'b1;
        end else begin
          mem_re_d   = 1'b1;
          mem_addr_d = sp_q + ONE;
        end
      end
      ST_SP_UPD: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        // Popped data only becomes visible when the POP completes.
        if (pop_q) rsp_rdata_d = rdata_q;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pop_q       <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sp_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      sp_we_q     <= 1'b0;
      sp_next_q   <= '0;
      sp_is_pop_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pop_q       <= pop_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sp_q        <= sp_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      sp_we_q     <= sp_we_d;
      sp_next_q   <= sp_next_d;
      sp_is_pop_q <= sp_is_pop_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.sp_we     = sp_we_q;
  assign bus.sp_next   = sp_next_q;
  assign bus.sp_is_pop = sp_is_pop_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: memory and pointer-register models, response scoreboard, vector table.
module tb_stack_sequencer;
  import stack_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  stack_sequencer_if #(.DW(8), .AW(8)) bus ();

  stack_sequencer #(.DW(8), .AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [7:0] mem [256];
  logic [7:0] sp_reg;
  logic       sp_load;
  logic [7:0] sp_load_val;
  int         wait_cfg;
  int         wcnt;

  assign bus.sp_cur    = sp_reg;
  assign bus.mem_ready = (bus.mem_we || bus.mem_re) && (wcnt >= wait_cfg);
  assign bus.mem_rdata = mem[bus.mem_addr];

  initial wcnt = 0;
  always @(posedge clk) begin
    wcnt <= ((bus.mem_we || bus.mem_re) && !bus.mem_ready) ? wcnt + 1 : 0;
    if (bus.mem_we && bus.mem_ready) mem[bus.mem_addr] <= bus.mem_wdata;
    if (sp_load) sp_reg <= sp_load_val;
    else if (bus.sp_we) sp_reg <= bus.sp_next;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];
  int         sp_we_cnt = 0;
  int         acc_cnt = 0;
  int         overlap_cnt = 0;
  logic [7:0] last_addr;
  logic [7:0] last_sp_next;
  logic       last_is_pop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sp_we) begin
        sp_we_cnt++;
        last_sp_next = bus.sp_next;
        last_is_pop  = bus.sp_is_pop;
      end
      if ((bus.mem_we || bus.mem_re) && bus.mem_ready) begin
        acc_cnt++;
        last_addr = bus.mem_addr;
      end
      if ((bus.mem_we && bus.mem_re) || ((bus.mem_we || bus.mem_re) && bus.sp_we))
        overlap_cnt++;
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rsp_unexpected: got err=%0b data=%0h expected no response",
                   bus.rsp_err, bus.rsp_rdata);
        end else begin
          check("rsp_err_data", {23'd0, bus.rsp_err, bus.rsp_rdata}, {23'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_sp(input logic [7:0] v);
    sp_load_val = v;
    sp_load     = 1'b1;
    @(negedge clk);
    sp_load     = 1'b0;
  endtask

  // Entered and left at a negedge with the sequencer idle.
  task automatic do_req(input logic pop, input logic [7:0] wd, input int wt,
                        input logic exp_err, input logic [7:0] exp_rd, output int rsp_cyc);
    exp_q.push_back({exp_err, exp_rd});
    wait_cfg      = wt;
    bus.req_pop   = pop;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rsp_cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        rsp_cyc = k;
        break;
      end
    end
    if (rsp_cyc < 0) check("rsp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("ready_after_rsp", {31'd0, bus.req_ready}, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       pop;
    logic [7:0] wd;
    int         wt;
    logic       err;
    logic [7:0] rd;
    logic [7:0] sp;
    logic [7:0] addr;
    int         cyc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cyc;
    int we0;
    int acc0;
    int fill_err;

    vecs[0] = '{1'b0, 8'hA5, 0, 1'b0, 8'h00, 8'hFE, 8'hFF, 3};
    vecs[1] = '{1'b0, 8'h3C, 0, 1'b0, 8'h00, 8'hFD, 8'hFE, 3};
    vecs[2] = '{1'b1, 8'h00, 0, 1'b0, 8'h3C, 8'hFE, 8'hFE, 3};
    vecs[3] = '{1'b1, 8'h00, 0, 1'b0, 8'hA5, 8'hFF, 8'hFF, 3};
    vecs[4] = '{1'b1, 8'h00, 0, 1'b1, 8'hA5, 8'hFF, 8'h00, 1};
    vecs[5] = '{1'b0, 8'h11, 1, 1'b0, 8'hA5, 8'hFE, 8'hFF, 4};
    vecs[6] = '{1'b1, 8'h00, 0, 1'b0, 8'h11, 8'hFF, 8'hFF, 3};

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_pop   = 1'b0;
    bus.req_wdata = 8'h00;
    sp_load       = 1'b0;
    sp_load_val   = 8'h00;
    wait_cfg      = 0;

    // reset state
    @(negedge clk);
    load_sp(8'hFF);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_outputs", {27'd0, bus.rsp_valid, bus.mem_we, bus.mem_re, bus.sp_we, bus.rsp_err}, 32'd0);
    check("rst_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("empty_at_top", {30'd0, bus.empty, bus.full}, 32'd2);

    // table-driven requests with fixed-latency memory
    for (int i = 0; i < 7; i++) begin
      we0  = sp_we_cnt;
      acc0 = acc_cnt;
      do_req(vecs[i].pop, vecs[i].wd, vecs[i].wt, vecs[i].err, vecs[i].rd, cyc);
      check($sformatf("v%0d_rsp_cycle", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d_sp", i), {24'd0, sp_reg}, {24'd0, vecs[i].sp});
      check($sformatf("v%0d_sp_we_count", i), sp_we_cnt - we0, vecs[i].err ? 0 : 1);
      check($sformatf("v%0d_mem_count", i), acc_cnt - acc0, vecs[i].err ? 0 : 1);
      if (!vecs[i].err) begin
        check($sformatf("v%0d_addr", i), {24'd0, last_addr}, {24'd0, vecs[i].addr});
        check($sformatf("v%0d_is_pop", i), {31'd0, last_is_pop}, {31'd0, vecs[i].pop});
      end
    end

    // POP with two memory wait states
    do_req(1'b0, 8'hA5, 0, 1'b0, 8'h11, cyc);
    do_req(1'b1, 8'h00, 2, 1'b0, 8'hA5, cyc);
    check("wait_rsp_cycle", cyc, 5);
    check("wait_rd_addr", {24'd0, last_addr}, 32'hFF);
    check("wait_sp_next", {24'd0, last_sp_next}, 32'hFF);
    check("wait_is_pop", {31'd0, last_is_pop}, 32'd1);

    // PUSH while full
    load_sp(8'h7F);
    check("full_flag", {30'd0, bus.full, bus.empty}, 32'd2);
    we0  = sp_we_cnt;
    acc0 = acc_cnt;
    do_req(1'b0, 8'h77, 0, 1'b1, 8'hA5, cyc);
    check("full_rsp_cycle", cyc, 1);
    check("full_no_mem", acc_cnt - acc0, 0);
    check("full_no_sp_we", sp_we_cnt - we0, 0);

    // fill from top: 128 pushes succeed, 129th errors
    load_sp(8'hFF);
    fill_err = 0;
    for (int i = 0; i < 128; i++) begin
      do_req(1'b0, 8'(i), 0, 1'b0, 8'hA5, cyc);
      if (cyc != 3) fill_err++;
    end
    check("fill_latency", fill_err, 0);
    check("fill_sp", {24'd0, sp_reg}, 32'h7F);
    check("fill_full", {31'd0, bus.full}, 32'd1);
    do_req(1'b0, 8'hEE, 0, 1'b1, 8'hA5, cyc);
    check("overflow_rsp_cycle", cyc, 1);
    check("overflow_sp", {24'd0, sp_reg}, 32'h7F);

    // reset in the middle of a stalled write
    load_sp(8'hFF);
    we0           = sp_we_cnt;
    wait_cfg      = 1000;
    bus.req_pop   = 1'b0;
    bus.req_wdata = 8'h5A;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_mem_we", {31'd0, bus.mem_we}, 32'd1);
    check("abort_mem_addr", {24'd0, bus.mem_addr}, 32'hFF);
    @(negedge clk);
    check("abort_stall", {31'd0, bus.mem_we}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_we_drop", {29'd0, bus.mem_we, bus.mem_re, bus.sp_we}, 32'd0);
    check("abort_ready_low", {31'd0, bus.req_ready}, 32'd0);
    check("abort_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    wait_cfg = 0;
    @(negedge clk);
    check("abort_ready_after", {31'd0, bus.req_ready}, 32'd1);
    check("abort_no_sp_we", sp_we_cnt - we0, 0);
    check("abort_sp_kept", {24'd0, sp_reg}, 32'hFF);
    do_req(1'b0, 8'h5A, 0, 1'b0, 8'h00, cyc);
    check("post_abort_cycle", cyc, 3);
    check("post_abort_sp", {24'd0, sp_reg}, 32'hFE);
    do_req(1'b1, 8'h00, 0, 1'b0, 8'h5A, cyc);
    check("post_abort_pop_sp", {24'd0, sp_reg}, 32'hFF);

    // global properties
    check("strobe_overlap", overlap_cnt, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
